// File: rtl/ofifo_param.sv
// Output FIFO array: one lane per PE column, all lanes popped together as one registered row.
// Optional sticky overflow/underflow flags are built when OFIFO_PARAM_ERR_FLAG_EN is defined.
module ofifo_param #(
    parameter int col      = 8,
    parameter int bw       = 16,
    parameter int depth_lg = 6,
    parameter int af_mgn   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [col-1:0]      wr,
    input  logic [bw*col-1:0]   in,
    input  logic                rd,
    output logic [bw*col-1:0]   out,
    output logic                o_full,
    output logic                o_afull,
    output logic                o_ready,
    output logic                o_valid,
    output logic [depth_lg:0]   o_level,
    output logic                o_ovf,
    output logic                o_udf
);

    localparam int DEPTH = 1 << depth_lg;
    localparam logic [depth_lg:0] DEPTH_C = (depth_lg+1)'(DEPTH);
    localparam logic [depth_lg:0] AF_C    = (depth_lg+1)'(DEPTH - af_mgn);

    logic [bw-1:0]       mem [col][DEPTH];
    logic [depth_lg:0]   cnt [col];
    logic [depth_lg-1:0] wptr [col];
    logic [depth_lg-1:0] rptr;

    logic [col-1:0]      lane_full;
    logic [col-1:0]      lane_afull;
    logic [col-1:0]      lane_nempty;
    logic [col-1:0]      wr_ok;
    logic [depth_lg:0]   min_cnt;
    logic                pop;

    always_comb begin
        min_cnt = cnt[0];
        for (int i = 0; i < col; i++) begin
            lane_full[i]   = (cnt[i] == DEPTH_C);
            lane_afull[i]  = (cnt[i] >= AF_C);
            lane_nempty[i] = (cnt[i] != '0);
            if (cnt[i] < min_cnt) min_cnt = cnt[i];
        end
    end

    // Handshakes: a lane write is taken when wr[i] is high and that lane is not full;
    // a row pop is taken when rd and o_valid are both high before the edge. o_ready is
    // the aggregate "no lane full" hint; per-lane fullness still gates each write.
    assign wr_ok   = wr & ~lane_full;
    assign o_valid = &lane_nempty;
    assign pop     = rd & o_valid;
    assign o_full  = |lane_full;
    assign o_afull = |lane_afull;
    assign o_ready = ~o_full;
    assign o_level = min_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr <= '0;
            for (int i = 0; i < col; i++) begin
                cnt[i]  <= '0;
                wptr[i] <= '0;
            end
        end else begin
            if (pop) rptr <= rptr + 1'b1;
            for (int i = 0; i < col; i++) begin
                if (wr_ok[i]) wptr[i] <= wptr[i] + 1'b1;
                if (wr_ok[i] && !pop)      cnt[i] <= cnt[i] + 1'b1;
                else if (!wr_ok[i] && pop) cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    // Storage carries no reset; stale entries are unreachable once counts clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (wr_ok[i]) mem[i][wptr[i]] <= in[bw*i +: bw];
        end
    end

    // Shared rptr is safe: a pop only happens when every lane holds at least one entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= '0;
        end else if (pop) begin
            for (int i = 0; i < col; i++) begin
                out[bw*i +: bw] <= mem[i][rptr];
            end
        end
    end

`ifdef OFIFO_PARAM_ERR_FLAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_ovf <= 1'b0;
            o_udf <= 1'b0;
        end else begin
            if (|(wr & lane_full)) o_ovf <= 1'b1;
            if (rd && !o_valid)    o_udf <= 1'b1;
        end
    end
`else
    assign o_ovf = 1'b0;
    assign o_udf = 1'b0;
`endif

endmodule

// File: tb/tb_ofifo_param.sv
// Bench for ofifo_param: per-lane queue model, popped-row scoreboard, scenario tasks, summary report.
module tb_ofifo_param;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;
    localparam int AF    = 60;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [COL-1:0]     wr = '0;
    logic [BW*COL-1:0]  in_d = '0;
    logic               rd = 1'b0;
    logic [BW*COL-1:0]  out;
    logic               o_full, o_afull, o_ready, o_valid, o_ovf, o_udf;
    logic [6:0]         o_level;

    ofifo_param dut (
        .clk(clk), .reset(reset), .wr(wr), .in(in_d), .rd(rd), .out(out),
        .o_full(o_full), .o_afull(o_afull), .o_ready(o_ready), .o_valid(o_valid),
        .o_level(o_level), .o_ovf(o_ovf), .o_udf(o_udf)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: one queue per lane, popped rows go to the scoreboard queue
    logic [BW-1:0]      lane_q [COL][$];
    logic [BW*COL-1:0]  exp_q [$];
    logic [BW*COL-1:0]  exp_out;
    logic               m_ovf, m_udf;
    int                 n_tests = 0;
    int                 n_fail  = 0;

    function automatic int m_level();
        int m = DEPTH + 1;
        for (int i = 0; i < COL; i++)
            if (lane_q[i].size() < m) m = lane_q[i].size();
        return m;
    endfunction

    function automatic logic m_valid();
        return m_level() >= 1;
    endfunction

    function automatic logic m_full();
        logic f = 1'b0;
        for (int i = 0; i < COL; i++) if (lane_q[i].size() == DEPTH) f = 1'b1;
        return f;
    endfunction

    function automatic logic m_afull();
        logic f = 1'b0;
        for (int i = 0; i < COL; i++) if (lane_q[i].size() >= AF) f = 1'b1;
        return f;
    endfunction

    function automatic logic exp_ovf();
`ifdef OFIFO_PARAM_ERR_FLAG_EN
        return m_ovf;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_udf();
`ifdef OFIFO_PARAM_ERR_FLAG_EN
        return m_udf;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [BW*COL-1:0] rand_row();
        logic [BW*COL-1:0] r;
        for (int i = 0; i < COL; i++) r[BW*i +: BW] = BW'($urandom);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < COL; i++) lane_q[i].delete();
        exp_q.delete();
        exp_out = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // driver: apply one cycle of inputs at the falling edge, update the model from
    // pre-edge state, then return 1 time unit after the rising edge
    task automatic cycle(input logic [COL-1:0] w, input logic [BW*COL-1:0] d, input logic r);
        logic [BW*COL-1:0] row;
        logic [COL-1:0]    fl;
        logic              v;
        @(negedge clk);
        wr = w; in_d = d; rd = r;
        v = m_valid();
        for (int i = 0; i < COL; i++) fl[i] = (lane_q[i].size() == DEPTH);
        if (r && !v) m_udf = 1'b1;
        if (|(w & fl)) m_ovf = 1'b1;
        if (r && v) begin
            for (int i = 0; i < COL; i++) row[BW*i +: BW] = lane_q[i].pop_front();
            exp_q.push_back(row);
            exp_out = row;
        end
        for (int i = 0; i < COL; i++)
            if (w[i] && !fl[i]) lane_q[i].push_back(d[BW*i +: BW]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr = '0; rd = 1'b0; in_d = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        n_tests++; if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_tests++; if (o_level !== 7'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", o_level); end
        n_tests++; if (o_full !== 1'b0 || o_afull !== 1'b0) begin n_fail++; $display("FAIL reset_full: got full=%b afull=%b want 0 0", o_full, o_afull); end
        n_tests++; if (o_ovf !== 1'b0 || o_udf !== 1'b0) begin n_fail++; $display("FAIL reset_err: got ovf=%b udf=%b want 0 0", o_ovf, o_udf); end
    endtask

    task automatic test_stagger();
        logic [COL-1:0]    w;
        logic [BW*COL-1:0] d, want, e;
        for (int c = 0; c < 17; c++) begin
            w = '0; d = '0;
            for (int i = 0; i < COL; i++) begin
                if (c >= i && c < i + 10) begin
                    w[i] = 1'b1;
                    d[BW*i +: BW] = 16'(16'h0100 * i + (c - i));
                end
            end
            cycle(w, d, 1'b0);
            n_tests++; if (o_valid !== (c >= 7)) begin n_fail++; $display("FAIL stagger_valid c=%0d: got %b want %b", c, o_valid, (c >= 7)); end
        end
        n_tests++; if (o_level !== 7'd10) begin n_fail++; $display("FAIL stagger_level: got %0d want 10", o_level); end
        for (int k = 0; k < 10; k++) begin
            cycle('0, '0, 1'b1);
            e = exp_q.pop_front();
            for (int i = 0; i < COL; i++) want[BW*i +: BW] = 16'(16'h0100 * i + k);
            n_tests++; if (out !== want) begin n_fail++; $display("FAIL stagger_pop k=%0d: got %h want %h", k, out, want); end
            n_tests++; if (o_valid !== (k < 9)) begin n_fail++; $display("FAIL stagger_valid_drain k=%0d: got %b want %b", k, o_valid, (k < 9)); end
        end
    endtask

    task automatic test_full_wrap();
        logic [BW*COL-1:0] e;
        for (int k = 1; k <= DEPTH; k++) begin
            cycle('1, rand_row(), 1'b0);
            n_tests++; if (o_afull !== (k >= AF)) begin n_fail++; $display("FAIL full_afull k=%0d: got %b want %b", k, o_afull, (k >= AF)); end
            n_tests++; if (o_full !== (k == DEPTH) || o_ready !== (k != DEPTH)) begin n_fail++; $display("FAIL full_flag k=%0d: got full=%b ready=%b", k, o_full, o_ready); end
        end
        cycle('1, rand_row(), 1'b0);
        n_tests++; if (o_level !== 7'd64) begin n_fail++; $display("FAIL full_drop_level: got %0d want 64", o_level); end
        n_tests++; if (o_ovf !== exp_ovf()) begin n_fail++; $display("FAIL full_ovf: got %b want %b", o_ovf, exp_ovf()); end
        for (int rep = 0; rep < 2; rep++) begin
            if (rep == 1) for (int k = 0; k < DEPTH; k++) cycle('1, rand_row(), 1'b0);
            for (int k = 0; k < DEPTH; k++) begin
                cycle('0, '0, 1'b1);
                e = exp_q.pop_front();
                n_tests++; if (out !== e) begin n_fail++; $display("FAIL wrap_pop rep=%0d k=%0d: got %h want %h", rep, k, out, e); end
            end
            n_tests++; if (o_level !== 7'd0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty rep=%0d: got level=%0d valid=%b want 0 0", rep, o_level, o_valid); end
        end
    endtask

    task automatic test_concurrent();
        logic [BW*COL-1:0] e;
        for (int k = 0; k < 5; k++) cycle('1, rand_row(), 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle('1, rand_row(), 1'b1);
            e = exp_q.pop_front();
            n_tests++; if (out !== e) begin n_fail++; $display("FAIL conc_out k=%0d: got %h want %h", k, out, e); end
            n_tests++; if (o_level !== 7'd5) begin n_fail++; $display("FAIL conc_level k=%0d: got %0d want 5", k, o_level); end
        end
        for (int k = 0; k < 5; k++) begin
            cycle('0, '0, 1'b1);
            e = exp_q.pop_front();
            n_tests++; if (out !== e) begin n_fail++; $display("FAIL conc_drain k=%0d: got %h want %h", k, out, e); end
        end
    endtask

    task automatic test_underflow();
        logic [BW*COL-1:0] held, e;
        for (int k = 0; k < 4; k++) cycle(8'hF7, rand_row(), 1'b0);
        held = out;
        cycle('0, '0, 1'b1);
        n_tests++; if (out !== held) begin n_fail++; $display("FAIL udf_out: got %h want %h", out, held); end
        n_tests++; if (o_valid !== 1'b0 || o_level !== 7'd0) begin n_fail++; $display("FAIL udf_state: got valid=%b level=%0d want 0 0", o_valid, o_level); end
        n_tests++; if (o_udf !== exp_udf()) begin n_fail++; $display("FAIL udf_flag: got %b want %b", o_udf, exp_udf()); end
        for (int k = 0; k < 4; k++) cycle(8'h08, rand_row(), 1'b0);
        n_tests++; if (o_level !== 7'd4) begin n_fail++; $display("FAIL udf_level_after: got %0d want 4", o_level); end
        for (int k = 0; k < 4; k++) begin
            cycle('0, '0, 1'b1);
            e = exp_q.pop_front();
            n_tests++; if (out !== e) begin n_fail++; $display("FAIL udf_drain k=%0d: got %h want %h", k, out, e); end
        end
    endtask

    task automatic test_mid_reset();
        logic [BW*COL-1:0] e;
        for (int k = 0; k < 30; k++) cycle('1, rand_row(), 1'b0);
        cycle('0, '0, 1'b1);
        e = exp_q.pop_front();
        n_tests++; if (o_level !== 7'd29 || out !== e) begin n_fail++; $display("FAIL mrst_pre: got level=%0d out=%h want 29 %h", o_level, out, e); end
        #2 reset = 1'b0;
        #1;
        n_tests++; if (o_valid !== 1'b0 || o_level !== 7'd0) begin n_fail++; $display("FAIL mrst_async: got valid=%b level=%0d want 0 0", o_valid, o_level); end
        n_tests++; if (out !== '0) begin n_fail++; $display("FAIL mrst_out: got %h want 0", out); end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cycle('1, rand_row(), 1'b0);
        cycle('0, '0, 1'b1);
        e = exp_q.pop_front();
        n_tests++; if (out !== e) begin n_fail++; $display("FAIL mrst_new: got %h want %h", out, e); end
        n_tests++; if (o_valid !== 1'b0 || o_level !== 7'd0) begin n_fail++; $display("FAIL mrst_empty: got valid=%b level=%0d want 0 0", o_valid, o_level); end
    endtask

    task automatic test_random();
        logic [COL-1:0]    w;
        logic [BW*COL-1:0] e;
        for (int k = 0; k < 600; k++) begin
            w = ($urandom_range(0, 2) != 0) ? 8'hFF : 8'($urandom_range(0, 255));
            cycle(w, rand_row(), 1'($urandom_range(0, 2) == 0));
            e = (exp_q.size() != 0) ? exp_q.pop_front() : exp_out;
            n_tests++; if (out !== e) begin n_fail++; $display("FAIL rand_out k=%0d: got %h want %h", k, out, e); end
            n_tests++; if (o_level !== 7'(m_level()) || o_valid !== m_valid()) begin n_fail++; $display("FAIL rand_level k=%0d: got level=%0d valid=%b want %0d %b", k, o_level, o_valid, m_level(), m_valid()); end
            n_tests++; if (o_full !== m_full() || o_afull !== m_afull() || o_ready !== !m_full()) begin n_fail++; $display("FAIL rand_flags k=%0d: got full=%b afull=%b ready=%b", k, o_full, o_afull, o_ready); end
            n_tests++; if (o_ovf !== exp_ovf() || o_udf !== exp_udf()) begin n_fail++; $display("FAIL rand_err k=%0d: got ovf=%b udf=%b want %b %b", k, o_ovf, o_udf, exp_ovf(), exp_udf()); end
        end
    endtask

    initial begin
        test_reset();
        test_stagger();
        test_full_wrap();
        test_concurrent();
        test_underflow();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
